slow_mem_responder: RTL and testbench

//  Synthesizable responder for the 128-bit block memory interface driven by the cache hierarchy
//  (the mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_ready ports of the instruction and

---
 rtl/mem_if_pkg.sv | 20 ++
 rtl/mem_blk_array.sv | 44 ++++
 rtl/slow_mem_responder.sv | 130 +++++++++++++
 tb/tb_slow_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types for the 128-bit block memory interface.
// Used by the slow responder and its block RAM.
package mem_if_pkg;

    localparam int BLK_W   = 128;
    localparam int MADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic               is_wr;
        logic [MADDR_W-1:0] addr;
        logic [BLK_W-1:0]   wdata;
    } req_t;

endpackage

// File: rtl/mem_blk_array.sv
// Single-port block RAM with registered read data.
// Kept separate so an FPGA/SRAM macro can replace it.
module mem_blk_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [BLK_W-1:0]      wdata,
    output logic [BLK_W-1:0]      rdata
);

    logic [BLK_W-1:0] mem [2**DEPTH_LOG2];
    logic [BLK_W-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data holds between reads; writes never disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/slow_mem_responder.sv
// Fixed-latency block memory responder with protocol checking
// and saturating read/write transaction counters.
module slow_mem_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 10,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [MADDR_W-1:0] mem_addr,
    input  logic [BLK_W-1:0]   mem_wdata,
    output logic [BLK_W-1:0]   mem_rdata,
    output logic               mem_ready,
    output logic               proto_err,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   wr_count
);

    localparam int WCNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e            state_d, state_q;
    logic [WCNT_W-1:0] wcnt_d, wcnt_q;
    req_t              req_d, req_q;
    logic              ready_d, ready_q;
    logic              perr_d, perr_q;
    logic [CNT_W-1:0]  rd_cnt_d, rd_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_d, wr_cnt_q;

    logic req_any;
    logic viol;
    logic fire;

    assign req_any = mem_read | mem_write;
    assign fire    = (state_q == WAIT) && (wcnt_q == '0);

    // A simultaneous read+write is treated as a write, so op identity is mem_write.
    assign viol = !req_any
               || (mem_addr != req_q.addr)
               || (mem_write != req_q.is_wr)
               || (req_q.is_wr && (mem_wdata != req_q.wdata));

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        req_d    = req_q;
        ready_d  = 1'b0;
        perr_d   = perr_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    req_d.is_wr = mem_write;
                    req_d.addr  = mem_addr;
                    req_d.wdata = mem_wdata;
                    wcnt_d      = WCNT_W'(LATENCY - 1);
                    state_d     = WAIT;
                    if (mem_read && mem_write) begin
                        perr_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (viol) begin
                    perr_d = 1'b1;
                end
                if (wcnt_q == '0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (req_q.is_wr) begin
                        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            req_q    <= '0;
            ready_q  <= 1'b0;
            perr_q   <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            req_q    <= req_d;
            ready_q  <= ready_d;
            perr_q   <= perr_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Reset gates the RAM strobes so a pending write is dropped.
    mem_blk_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (fire && req_q.is_wr && !rst),
        .re    (fire && !req_q.is_wr && !rst),
        .addr  (req_q.addr[DEPTH_LOG2-1:0]),
        .wdata (req_q.wdata),
        .rdata (mem_rdata)
    );

    assign mem_ready = ready_q;
    assign proto_err = perr_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_slow_mem_responder.sv
// Scoreboard bench: one LATENCY=8 responder and one LATENCY=1,
// CNT_W=2 responder driven from shared transaction tasks.
module tb_slow_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst_i;
    logic [1:0]        rd_i;
    logic [1:0]        wr_i;
    logic [1:0][27:0]  addr_i;
    logic [1:0][127:0] wd_i;

    logic [127:0] rdat0, rdat1;
    logic         rdy0, rdy1, perr0, perr1;
    logic [15:0]  rdc0, wrc0;
    logic [1:0]   rdc1, wrc1;

    int checks = 0;
    int fails  = 0;

    logic [127:0] model [int];
    logic [127:0] exp_q [$];
    logic [127:0] last_rd [2];
    int           lat [2] = '{8, 1};

    localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] DA = 128'hAAAA0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] DB = 128'hBBBB0000_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam logic [127:0] DC = 128'hCCCC0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] DF = 128'hF00DF00D_0000_1234_0000_5678_0000_9ABC;
    localparam logic [127:0] DG = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

    slow_mem_responder #(
        .LATENCY    (8),
        .DEPTH_LOG2 (10),
        .CNT_W      (16)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst_i[0]),
        .mem_read  (rd_i[0]),
        .mem_write (wr_i[0]),
        .mem_addr  (addr_i[0]),
        .mem_wdata (wd_i[0]),
        .mem_rdata (rdat0),
        .mem_ready (rdy0),
        .proto_err (perr0),
        .rd_count  (rdc0),
        .wr_count  (wrc0)
    );

    slow_mem_responder #(
        .LATENCY    (1),
        .DEPTH_LOG2 (10),
        .CNT_W      (2)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst_i[1]),
        .mem_read  (rd_i[1]),
        .mem_write (wr_i[1]),
        .mem_addr  (addr_i[1]),
        .mem_wdata (wd_i[1]),
        .mem_rdata (rdat1),
        .mem_ready (rdy1),
        .proto_err (perr1),
        .rd_count  (rdc1),
        .wr_count  (wrc1)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 1) ? rdy1 : rdy0;
    endfunction

    function automatic logic [127:0] rdat(input int w);
        return (w == 1) ? rdat1 : rdat0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int w);
        rst_i[w] = 1'b1;
        rd_i[w]  = 1'b0;
        wr_i[w]  = 1'b0;
        tick();
        rst_i[w]   = 1'b0;
        last_rd[w] = '0;
    endtask

    task automatic xfer(input int w, input bit rd, input bit wr,
                        input logic [27:0] a, input logic [127:0] d,
                        input bit drop);
        int n;
        int key;
        logic [127:0] e;
        key = w * 1024 + int'(a[9:0]);
        rd_i[w]   = rd;
        wr_i[w]   = wr;
        addr_i[w] = a;
        wd_i[w]   = d;
        if (wr) model[key] = d;
        else exp_q.push_back(model.exists(key) ? model[key] : 128'h0);
        tick();
        n = 0;
        while (!rdy(w) && n < 40) begin
            if (drop && n == 2) rd_i[w] = 1'b0;
            tick();
            n++;
        end
        chk("latency", 128'(n), 128'(lat[w]));
        if (!wr) begin
            e = exp_q.pop_front();
            chk("rdata", rdat(w), e);
            last_rd[w] = e;
        end else begin
            chk("rdata_hold", rdat(w), last_rd[w]);
        end
        rd_i[w] = 1'b0;
        wr_i[w] = 1'b0;
        tick();
        chk("ready_pulse", 128'(rdy(w)), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst_i  = 2'b11;
        rd_i   = '0;
        wr_i   = '0;
        addr_i = '0;
        wd_i   = '0;
        tick();
        tick();
        rst_i = 2'b00;
        last_rd[0] = '0;
        last_rd[1] = '0;

        chk("rst_ready", 128'(rdy0), 128'(0));
        chk("rst_rdata", rdat0, 128'h0);
        chk("rst_perr", 128'(perr0), 128'(0));
        chk("rst_rdc", 128'(rdc0), 128'(0));
        chk("rst_wrc", 128'(wrc0), 128'(0));
        chk("rst_rdata1", rdat1, 128'h0);

        xfer(0, 1'b0, 1'b1, 28'h0000005, D1, 1'b0);
        xfer(0, 1'b1, 1'b0, 28'h0000005, 128'h0, 1'b0);
        chk("wr_rd_data", rdat0, D1);
        chk("wr_rd_rdc", 128'(rdc0), 128'(1));
        chk("wr_rd_wrc", 128'(wrc0), 128'(1));
        chk("wr_rd_perr", 128'(perr0), 128'(0));

        xfer(0, 1'b0, 1'b1, 28'h0000003, DA, 1'b0);
        xfer(0, 1'b0, 1'b1, 28'h0000403, DB, 1'b0);
        xfer(0, 1'b1, 1'b0, 28'h0000003, 128'h0, 1'b0);
        chk("wrap", rdat0, DB);

        rd_i[0]   = 1'b0;
        wr_i[0]   = 1'b1;
        addr_i[0] = 28'h0000003;
        wd_i[0]   = DC;
        tick();
        tick();
        tick();
        rst_i[0] = 1'b1;
        tick();
        rst_i[0]   = 1'b0;
        wr_i[0]    = 1'b0;
        last_rd[0] = '0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (rdy0) seen++;
            tick();
        end
        chk("rstmid_noready", 128'(seen), 128'(0));
        chk("rstmid_perr", 128'(perr0), 128'(0));
        chk("rstmid_wrc", 128'(wrc0), 128'(0));
        xfer(0, 1'b1, 1'b0, 28'h0000003, 128'h0, 1'b0);
        chk("rstmid_old", rdat0, DB);

        xfer(0, 1'b1, 1'b0, 28'h0000005, 128'h0, 1'b1);
        chk("drop_perr", 128'(perr0), 128'(1));
        chk("drop_data", rdat0, D1);

        do_reset(0);
        chk("perr_clr", 128'(perr0), 128'(0));
        xfer(0, 1'b1, 1'b1, 28'h0000008, DF, 1'b0);
        chk("both_perr", 128'(perr0), 128'(1));
        chk("both_wrc", 128'(wrc0), 128'(1));
        chk("both_rdc", 128'(rdc0), 128'(0));
        xfer(0, 1'b1, 1'b0, 28'h0000008, 128'h0, 1'b0);
        chk("both_data", rdat0, DF);

        xfer(1, 1'b0, 1'b1, 28'h0000001, DG, 1'b0);
        for (int i = 0; i < 3; i++) begin
            xfer(1, 1'b1, 1'b0, 28'h0000001, 128'h0, 1'b0);
        end
        chk("sat_rdc3", 128'(rdc1), 128'(3));
        for (int i = 0; i < 2; i++) begin
            xfer(1, 1'b1, 1'b0, 28'h0000001, 128'h0, 1'b0);
        end
        chk("sat_rdc5", 128'(rdc1), 128'(3));
        chk("sat_wrc", 128'(wrc1), 128'(1));
        chk("sat_data", rdat1, DG);
        chk("sat_perr", 128'(perr1), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
